mem_access_unit: RTL
====================

MEM_ACCESS_UNIT -- requirements
Module: mem_access_unit

Interface
REQ-001 Parameter TIMEOUT, default 64: max cycles from request to rvalid before bus error; range 2..255.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 reset  input  1  asynchronous, active-low: reset=0 clears all state immediately.
REQ-004 mem_read / mem_write  input  1 each  load/store request from MEM stage; held stable while stall=1.
REQ-005 funct3  input  3  access size/sign: 000 LB/SB, 001 LH/SH, 010 LW/SW, 100 LBU, 101 LHU; any other code is treated as word.
REQ-006 addr / store_data  input  32 each  byte address and store operand.
REQ-007 dmem_req, dmem_we  output  1 each  memory request and write enable.
REQ-008 dmem_addr  output  32  word-aligned address {addr[31:2],2'b00}.
REQ-009 dmem_be  output  4  byte enables.
REQ-010 dmem_wdata  output  32  lane-replicated store data.
REQ-011 dmem_gnt, dmem_rvalid  input  1 each  grant, and response/ack valid.
REQ-012 dmem_rdata  input  32  raw read word.
REQ-013 read_data  output  32  formatted load result for writeback select.
REQ-014 stall  output  1  holds pipeline while an access is outstanding.
REQ-015 bus_err, misaligned  output  1 each  one-cycle error pulses.

Function
REQ-016 FSM states: IDLE, REQ, WAIT, DONE.
REQ-017 IDLE: mem_read|mem_write latches addr, funct3, store_data, direction; next state is REQ. If both are high, write has priority.
REQ-018 REQ: dmem_req=1 with registered fields. On dmem_gnt, go to WAIT. On dmem_gnt and dmem_rvalid in the same cycle, go straight to DONE.
REQ-019 WAIT: dmem_req=0. On dmem_rvalid, go to DONE. Loads capture formatted dmem_rdata; stores treat rvalid as the write ack.
REQ-020 DONE: held exactly one cycle with stall=0 and read_data valid; returns to IDLE.
REQ-021 Back-to-back accesses have minimum 3-cycle latency (IDLE->REQ->DONE) when gnt and rvalid arrive together.
REQ-022 stall = (mem_read|mem_write) while state != DONE.
REQ-023 Timeout counter: 8 bits, cleared on entry to REQ, increments each cycle in REQ/WAIT. At TIMEOUT-1 the FSM forces DONE with bus_err=1, read_data=0, and dmem_req dropped.
REQ-024 Load format by addr[1:0]:
- LB/LBU select byte lane addr[1:0].
- LH/LHU select half-word lane addr[1].
- LB/LH sign-extend; LBU/LHU zero-extend.
REQ-025 Store byte enables:
- SB: dmem_be = 4'b0001 << addr[1:0], byte replicated ×4.
- SH: dmem_be = 0011 or 1100 per addr[1], half-word replicated ×2.
- SW: dmem_be = 1111.
- Loads: dmem_be = 1111.
REQ-026 read_data holds its last value until the next DONE. It is 0 after a store or an error.
REQ-027 dmem_rvalid or dmem_gnt arriving in IDLE or DONE is ignored.

Reset
REQ-028 While reset=0, the unit is in IDLE. All outputs are 0: dmem_req, dmem_we, dmem_be, dmem_addr, dmem_wdata, read_data, stall, bus_err, misaligned. The counter is 0.
REQ-029 Reset asserted mid-transaction (REQ/WAIT) abandons the access. A response arriving after reset release is ignored per REQ-027.

Configuration
REQ-030 Macro MISALIGN_TRAP_EN, when defined:
- Halfword with addr[0]=1, or word with addr[1:0]!=0, issues no memory request.
- FSM goes IDLE->DONE with misaligned=1 for one cycle, read_data=0.
REQ-031 Without MISALIGN_TRAP_EN:
- misaligned is tied to 0.
- Misaligned halfword/word accesses proceed with lanes taken as if addr[0] (halfword) or addr[1:0] (word) were 0.

Verification
REQ-032 LB, addr=0x103, dmem_rdata=0x80FF_FF12, gnt+rvalid same cycle -> dmem_addr=0x100, read_data=0xFFFF_FF80, stall low in DONE, 3 cycles total.
REQ-033 SH, addr=0x202, store_data=0x0000_BEEF, gnt delayed 2 cycles, rvalid 1 cycle later -> dmem_be=1100, dmem_wdata=0xBEEF_BEEF, dmem_we=1, stall high until DONE.
REQ-034 LW with TIMEOUT=4, gnt given, no rvalid -> bus_err pulse in the 4th cycle, read_data=0, FSM back to IDLE.
REQ-035 LHU, addr=0x2, rvalid asserted then reset pulsed low in WAIT -> all outputs 0 immediately; a late rvalid after release leaves read_data=0.
REQ-036 LW, addr=0x6 -> with MISALIGN_TRAP_EN: misaligned=1, no dmem_req. Without it: dmem_addr=0x4, normal word load.

Source files
------------

// File: rtl/mem_access_unit.sv
// Load/store unit between the MEM stage and a req/gnt/rvalid data bus, with lane formatting and access timeout.
// Optional macro MISALIGN_TRAP_EN: misaligned half/word accesses skip the bus and finish with a misaligned pulse.
module mem_access_unit #(
   parameter int TIMEOUT = 64
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        mem_read,
   input  logic        mem_write,
   input  logic [2:0]  funct3,
   input  logic [31:0] addr,
   input  logic [31:0] store_data,
   output logic        dmem_req,
   output logic        dmem_we,
   output logic [31:0] dmem_addr,
   output logic [3:0]  dmem_be,
   output logic [31:0] dmem_wdata,
   input  logic        dmem_gnt,
   input  logic        dmem_rvalid,
   input  logic [31:0] dmem_rdata,
   output logic [31:0] read_data,
   output logic        stall,
   output logic        bus_err,
   output logic        misaligned
);
   typedef enum logic [1:0] {IDLE, REQ, WAIT, DONE} state_t;
   localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

   state_t      state_reg, state_next;
   logic [31:0] addr_reg, wdata_src_reg, read_data_reg;
   logic [2:0]  funct3_reg;
   logic        is_write_reg;
   logic [7:0]  cnt_reg;
   logic        bus_err_reg;

   logic        req_any, rsp_accept, timeout_evt, trap_evt, in_misaligned;
   logic        size_byte, size_half, active;
   logic [7:0]  byte_sel;
   logic [15:0] half_sel;
   logic [31:0] load_fmt, wdata_fmt;
   logic [3:0]  be_fmt;

   assign req_any = mem_read | mem_write;

   // Access size of the latched request; unsigned codes only exist for loads
   assign size_byte = (funct3_reg == 3'b000) || (!is_write_reg && funct3_reg == 3'b100);
   assign size_half = (funct3_reg == 3'b001) || (!is_write_reg && funct3_reg == 3'b101);

`ifdef MISALIGN_TRAP_EN
   logic in_half, in_byte;
   logic misaligned_reg;
   always_comb begin
      in_byte       = (funct3 == 3'b000) || (!mem_write && funct3 == 3'b100);
      in_half       = (funct3 == 3'b001) || (!mem_write && funct3 == 3'b101);
      in_misaligned = (in_half && addr[0]) || (!in_half && !in_byte && (addr[1:0] != 2'b00));
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         misaligned_reg <= 1'b0;
      end else begin
         misaligned_reg <= trap_evt;
      end
   end
   assign misaligned = misaligned_reg;
`else
   assign in_misaligned = 1'b0;
   assign misaligned    = 1'b0;
`endif

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_reg <= IDLE;
      end else begin
         state_reg <= state_next;
      end
   end

   // A response in the last allowed cycle wins over the timeout
   always_comb begin
      state_next  = state_reg;
      rsp_accept  = 1'b0;
      timeout_evt = 1'b0;
      trap_evt    = 1'b0;
      case (state_reg)
         IDLE: begin
            if (req_any) begin
               if (in_misaligned) begin
                  trap_evt   = 1'b1;
                  state_next = DONE;
               end else begin
                  state_next = REQ;
               end
            end
         end
         REQ: begin
            if (dmem_gnt && dmem_rvalid) begin
               rsp_accept = 1'b1;
               state_next = DONE;
            end else if (cnt_reg == CNT_LAST) begin
               timeout_evt = 1'b1;
               state_next  = DONE;
            end else if (dmem_gnt) begin
               state_next = WAIT;
            end
         end
         WAIT: begin
            if (dmem_rvalid) begin
               rsp_accept = 1'b1;
               state_next = DONE;
            end else if (cnt_reg == CNT_LAST) begin
               timeout_evt = 1'b1;
               state_next  = DONE;
            end
         end
         DONE:    state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         addr_reg      <= '0;
         wdata_src_reg <= '0;
         funct3_reg    <= '0;
         is_write_reg  <= 1'b0;
         cnt_reg       <= '0;
         read_data_reg <= '0;
         bus_err_reg   <= 1'b0;
      end else begin
         bus_err_reg <= timeout_evt;
         if (state_reg == IDLE && req_any) begin
            addr_reg      <= addr;
            wdata_src_reg <= store_data;
            funct3_reg    <= funct3;
            is_write_reg  <= mem_write;
         end
         if (state_next == REQ && state_reg != REQ) begin
            cnt_reg <= '0;
         end else if (state_reg == REQ || state_reg == WAIT) begin
            cnt_reg <= cnt_reg + 8'd1;
         end
         if (rsp_accept) begin
            read_data_reg <= is_write_reg ? 32'd0 : load_fmt;
         end else if (timeout_evt || trap_evt) begin
            read_data_reg <= '0;
         end
      end
   end

   // Lane selection ignores the low address bits a half/word access would not use
   always_comb begin
      case (addr_reg[1:0])
         2'd0:    byte_sel = dmem_rdata[7:0];
         2'd1:    byte_sel = dmem_rdata[15:8];
         2'd2:    byte_sel = dmem_rdata[23:16];
         default: byte_sel = dmem_rdata[31:24];
      endcase
      half_sel = addr_reg[1] ? dmem_rdata[31:16] : dmem_rdata[15:0];
      if (size_byte) begin
         load_fmt = funct3_reg[2] ? {24'd0, byte_sel} : {{24{byte_sel[7]}}, byte_sel};
      end else if (size_half) begin
         load_fmt = funct3_reg[2] ? {16'd0, half_sel} : {{16{half_sel[15]}}, half_sel};
      end else begin
         load_fmt = dmem_rdata;
      end
   end

   always_comb begin
      if (size_byte) begin
         be_fmt    = 4'b0001 << addr_reg[1:0];
         wdata_fmt = {4{wdata_src_reg[7:0]}};
      end else if (size_half) begin
         be_fmt    = addr_reg[1] ? 4'b1100 : 4'b0011;
         wdata_fmt = {2{wdata_src_reg[15:0]}};
      end else begin
         be_fmt    = 4'b1111;
         wdata_fmt = wdata_src_reg;
      end
      if (!is_write_reg) begin
         be_fmt    = 4'b1111;
         wdata_fmt = '0;
      end
   end

   always_comb begin
      active     = (state_reg == REQ) || (state_reg == WAIT);
      dmem_req   = (state_reg == REQ);
      dmem_we    = active && is_write_reg;
      dmem_addr  = active ? {addr_reg[31:2], 2'b00} : 32'd0;
      dmem_be    = active ? be_fmt : 4'd0;
      dmem_wdata = active ? wdata_fmt : 32'd0;
      stall      = reset && req_any && (state_reg != DONE);
      read_data  = read_data_reg;
      bus_err    = bus_err_reg;
   end
endmodule
